vga_frame_scanner: RTL and testbench
====================================

VGA_FRAME_SCANNER -- requirements
Module: vga_frame_scanner

Interface
REQ-001 SHALL have parameter H_RES, default 320, meaning pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, meaning lines per frame.
REQ-003 SHALL have parameter COLOR_W, default 3, meaning bits per pixel.
REQ-004 SHALL have parameter NUM_SCREENS, default 4, meaning number of image ROM lanes (min 2).
REQ-005 SHALL have parameter ROM_LAT, default 1, meaning ROM read latency in cycles (1..4).
REQ-006 SHALL have parameter CURSOR_MODE, default 0, meaning 0 = crosshair, 1 = filled square.
REQ-007 SHALL have parameter CURSOR_SIZE, default 2, meaning square half-width in pixels.
REQ-008 SHALL have parameter CURSOR_COLOR, default 0, meaning cursor pixel colour.
REQ-009 SHALL have widths derived: X_W=clog2(H_RES), Y_W=clog2(V_RES), A_W=clog2(H_RES*V_RES), S_W=max(1,clog2(NUM_SCREENS)).
REQ-010 SHALL have one clock and a synchronous active-high reset: clk  in  1  clock; iReset  in  1  synchronous active-high reset.
REQ-011 SHALL have ports: V_SYNC  in  1  display vertical sync; keyPress  in  1  screen-advance key, high = pressed.
REQ-012 SHALL have ports: iMouseX  in  X_W  cursor x; iMouseY  in  Y_W  cursor y.
REQ-013 SHALL have port iPixData  in  NUM_SCREENS*COLOR_W  ROM data, lane i = bits [i*COLOR_W +: COLOR_W] for screen i.
REQ-014 SHALL have ports: oAddress  out  A_W  ROM read address, shared by all lanes; oScreen  out  S_W  screen being drawn.
REQ-015 SHALL have ports: x  out  X_W; y  out  Y_W; color  out  COLOR_W; writeEn  out  1  pixel strobe; oFrameDone  out  1  one-cycle pulse.

Function
REQ-016 Screen FSM SHALL have states SHOW and HOLD; SHOW with keyPress=1 -> HOLD and selScreen increments, wrapping NUM_SCREENS-1 -> 0.
REQ-017 HOLD SHALL remain while keyPress=1 and return to SHOW when keyPress=0; exactly one advance per press.
REQ-018 Draw FSM SHALL have states IDLE, SCAN, DRAIN; it leaves IDLE only on a V_SYNC falling edge (registered prev=1, current=0).
REQ-019 On the edge cycle, the block SHALL capture iMouseX/iMouseY (each clamped to H_RES-1/V_RES-1) and copy selScreen to oScreen; frame contents never change mid-frame.
REQ-020 In SCAN, oAddress SHALL equal 0 in the first cycle and increment by 1 per cycle up to H_RES*V_RES-1, then enter DRAIN.
REQ-021 The issued pixel coordinates SHALL satisfy x = addr mod H_RES and y = addr div H_RES, computed by counters, not division.
REQ-022 x, y, the cursor flag and the valid flag SHALL be delayed ROM_LAT cycles so that writeEn=1 in the cycle that lane oScreen of iPixData holds the data for (x,y).
REQ-023 Crosshair mode SHALL mark a pixel as cursor when x==mouseX or y==mouseY; square mode SHALL mark it when |x-mouseX|<=CURSOR_SIZE and |y-mouseY|<=CURSOR_SIZE, with no wrap at edges.
REQ-024 color SHALL equal CURSOR_COLOR on cursor pixels and otherwise the selected lane.
REQ-025 DRAIN SHALL last ROM_LAT cycles; in its last cycle oFrameDone=1, and the next state is IDLE.
REQ-026 V_SYNC edges arriving during SCAN/DRAIN SHALL be ignored, and that frame is skipped.
REQ-027 Each frame SHALL assert writeEn for exactly H_RES*V_RES cycles, contiguous, outside of reset.
REQ-028 A key press simultaneous with the V_SYNC edge SHALL take effect on the following frame.

Reset
REQ-029 During iReset, the block SHALL set Draw FSM=IDLE, Screen FSM=SHOW, selScreen=oScreen=0, oAddress=0, x=y=0, color=0, writeEn=0, oFrameDone=0, V_SYNC prev=0, and flush the delay pipeline.
REQ-030 Reset mid-frame SHALL abort the scan with no oFrameDone, and the first edge after release SHALL start a full frame.

Structure
REQ-031 Shared package vga_pkg SHALL hold the FSM state encodings, the CURSOR_MODE constants and the width-derivation function.
REQ-032 A single sub-module vga_delay_line (parametrised width and depth ROM_LAT, synchronous reset) SHALL implement the alignment pipeline.

Verification
REQ-033 With H_RES=8, V_RES=4, ROM_LAT=2, pulse V_SYNC 1->0, the bench SHALL check addresses 0..31 on consecutive cycles, writeEn high for exactly 32 cycles starting 2 cycles after address 0, and oFrameDone 2 cycles after address 31.
REQ-034 With lane data = address for screen 0 and mouse at (3,1) in crosshair mode, the bench SHALL check that color=CURSOR_COLOR exactly at x=3 or y=1 and equals the lane value elsewhere.
REQ-035 With the square mode, CURSOR_SIZE=1 and mouse (0,0), the bench SHALL check that the cursor covers only (0,0),(1,0),(0,1),(1,1), with no wrap to x=7.
REQ-036 With NUM_SCREENS=3, pressing the key three times (held 5 cycles each), the bench SHALL check that oScreen across successive frames is 1,2,0, and that the key held through two frames advances once.
REQ-037 With a second V_SYNC fall during SCAN and a reset at address 10, the bench SHALL check that the extra edge is ignored, that the reset gives writeEn=0 next cycle with no oFrameDone, and that the next edge starts at address 0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, constants and width helper for the VGA frame scanner
// Contents:
//   drawState_t   : draw FSM encoding (IDLE, SCAN, DRAIN)
//   screenState_t : screen-select FSM encoding (SHOW, HOLD)
//   CURSOR_*      : CURSOR_MODE values
//   widthOf()     : counter width for a count of n, never below 1 bit
package vga_pkg;

  typedef enum logic [1:0] {
    DRAW_IDLE  = 2'd0,
    DRAW_SCAN  = 2'd1,
    DRAW_DRAIN = 2'd2
  } drawState_t;

  typedef enum logic {
    SCR_SHOW = 1'b0,
    SCR_HOLD = 1'b1
  } screenState_t;

  localparam int CURSOR_CROSSHAIR = 0;
  localparam int CURSOR_SQUARE    = 1;

  function automatic int widthOf(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register pipeline with synchronous flush
// Ports:
//   clk    in  1      clock
//   iReset in  1      synchronous active-high reset, clears every stage
//   dIn    in  WIDTH  value entering the pipeline
//   dOut   out WIDTH  dIn delayed by DEPTH cycles
module vga_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             iReset,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] dOut
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (iReset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= dIn;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dOut = stages[DEPTH-1];

endmodule

// File: rtl/vga_frame_scanner.sv
// rtl/vga_frame_scanner.sv - scans one full frame of ROM pixels per V_SYNC fall, with cursor overlay
// Ports:
//   clk, iReset        clock, synchronous active-high reset
//   V_SYNC             display vertical sync; a falling edge starts a frame when idle
//   keyPress           advances the selected screen once per press
//   iMouseX, iMouseY   cursor position, sampled at frame start
//   iPixData           ROM data, one COLOR_W lane per screen
//   oAddress, oScreen  ROM address shared by all lanes, screen being drawn
//   x, y, color        pixel coordinate and colour, valid while writeEn=1
//   writeEn            pixel strobe
//   oFrameDone         one-cycle pulse with the last pixel of a frame
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter  int H_RES        = 320,
  parameter  int V_RES        = 240,
  parameter  int COLOR_W      = 3,
  parameter  int NUM_SCREENS  = 4,
  parameter  int ROM_LAT      = 1,
  parameter  int CURSOR_MODE  = 0,
  parameter  int CURSOR_SIZE  = 2,
  parameter  int CURSOR_COLOR = 0,
  localparam int X_W          = widthOf(H_RES),
  localparam int Y_W          = widthOf(V_RES),
  localparam int A_W          = widthOf(H_RES * V_RES),
  localparam int S_W          = widthOf(NUM_SCREENS)
) (
  input  logic                           clk,
  input  logic                           iReset,
  input  logic                           V_SYNC,
  input  logic                           keyPress,
  input  logic [X_W-1:0]                 iMouseX,
  input  logic [Y_W-1:0]                 iMouseY,
  input  logic [NUM_SCREENS*COLOR_W-1:0] iPixData,
  output logic [A_W-1:0]                 oAddress,
  output logic [S_W-1:0]                 oScreen,
  output logic [X_W-1:0]                 x,
  output logic [Y_W-1:0]                 y,
  output logic [COLOR_W-1:0]             color,
  output logic                           writeEn,
  output logic                           oFrameDone
);

  localparam logic [A_W-1:0] LAST_ADDR = A_W'(H_RES * V_RES - 1);
  localparam logic [X_W-1:0] LAST_X    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] LAST_Y    = Y_W'(V_RES - 1);
  localparam logic [S_W-1:0] LAST_SCR  = S_W'(NUM_SCREENS - 1);
  localparam logic [2:0]     LAST_DRN  = 3'(ROM_LAT - 1);
  localparam logic [31:0]    CSIZE     = 32'(CURSOR_SIZE);
  localparam int             PL_W      = 2 + X_W + Y_W;

  // Screen select: one advance per press, held key parks in HOLD.
  screenState_t scrState, scrNext;
  logic [S_W-1:0] selScreen, selNext;

  always_ff @(posedge clk) begin
    if (iReset) begin
      scrState  <= SCR_SHOW;
      selScreen <= '0;
    end else begin
      scrState  <= scrNext;
      selScreen <= selNext;
    end
  end

  always_comb begin
    scrNext = scrState;
    selNext = selScreen;
    case (scrState)
      SCR_SHOW: if (keyPress) begin
        scrNext = SCR_HOLD;
        selNext = (selScreen == LAST_SCR) ? '0 : selScreen + S_W'(1);
      end
      SCR_HOLD: if (!keyPress) scrNext = SCR_SHOW;
      default:  scrNext = SCR_SHOW;
    endcase
  end

  // Draw FSM
  drawState_t drawState, drawNext;
  logic           vSyncPrev;
  logic           fallEdge;
  logic           lastPix;
  logic           drainLast;
  logic           scanValid;
  logic [2:0]     drainCnt;
  logic [X_W-1:0] xCnt, mouseX;
  logic [Y_W-1:0] yCnt, mouseY;

  assign fallEdge  = vSyncPrev & ~V_SYNC;
  assign lastPix   = (oAddress == LAST_ADDR);
  assign drainLast = (drainCnt == LAST_DRN);

  always_ff @(posedge clk) begin
    if (iReset) drawState <= DRAW_IDLE;
    else        drawState <= drawNext;
  end

  always_comb begin
    drawNext   = drawState;
    scanValid  = 1'b0;
    oFrameDone = 1'b0;
    case (drawState)
      DRAW_IDLE:  if (fallEdge) drawNext = DRAW_SCAN;
      DRAW_SCAN: begin
        scanValid = 1'b1;
        if (lastPix) drawNext = DRAW_DRAIN;
      end
      DRAW_DRAIN: if (drainLast) begin
        drawNext   = DRAW_IDLE;
        oFrameDone = !iReset;
      end
      default:    drawNext = DRAW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      vSyncPrev <= 1'b0;
      oAddress  <= '0;
      oScreen   <= '0;
      xCnt      <= '0;
      yCnt      <= '0;
      mouseX    <= '0;
      mouseY    <= '0;
      drainCnt  <= '0;
    end else begin
      vSyncPrev <= V_SYNC;
      case (drawState)
        DRAW_IDLE: if (fallEdge) begin
          // Everything the frame depends on is frozen here.
          oAddress <= '0;
          xCnt     <= '0;
          yCnt     <= '0;
          mouseX   <= (iMouseX > LAST_X) ? LAST_X : iMouseX;
          mouseY   <= (iMouseY > LAST_Y) ? LAST_Y : iMouseY;
          oScreen  <= selScreen;
        end
        DRAW_SCAN: begin
          drainCnt <= '0;
          if (!lastPix) begin
            oAddress <= oAddress + A_W'(1);
            if (xCnt == LAST_X) begin
              xCnt <= '0;
              yCnt <= yCnt + Y_W'(1);
            end else begin
              xCnt <= xCnt + X_W'(1);
            end
          end
        end
        DRAW_DRAIN: drainCnt <= drainCnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Cursor hit test on the pixel being issued; distances are unsigned so edges never wrap.
  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;
  logic           isCursor;

  always_comb begin
    dx = (xCnt >= mouseX) ? xCnt - mouseX : mouseX - xCnt;
    dy = (yCnt >= mouseY) ? yCnt - mouseY : mouseY - yCnt;
    if (CURSOR_MODE == CURSOR_SQUARE)
      isCursor = (32'(dx) <= CSIZE) && (32'(dy) <= CSIZE);
    else
      isCursor = (xCnt == mouseX) || (yCnt == mouseY);
  end

  // Align the issued pixel with the ROM data that arrives ROM_LAT cycles later.
  logic dCursor;

  vga_delay_line #(
    .WIDTH (PL_W),
    .DEPTH (ROM_LAT)
  ) uDelay (
    .clk    (clk),
    .iReset (iReset),
    .dIn    ({scanValid, isCursor, xCnt, yCnt}),
    .dOut   ({writeEn, dCursor, x, y})
  );

  logic [COLOR_W-1:0] laneData;

  always_comb begin
    laneData = '0;
    for (int i = 0; i < NUM_SCREENS; i++)
      if (oScreen == S_W'(i)) laneData = iPixData[i*COLOR_W +: COLOR_W];
  end

  always_comb begin
    color = '0;
    if (writeEn) color = dCursor ? COLOR_W'(CURSOR_COLOR) : laneData;
  end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb/tb_vga_frame_scanner.sv - directed bench: 8x4 frame, ROM_LAT=2, crosshair and square cursor DUTs
module tb_vga_frame_scanner;

  localparam int CUR = 6'h3F;

  logic        clk = 1'b0;
  logic        iReset;
  logic        V_SYNC;
  logic        keyPress;
  logic [2:0]  mouseXA, mouseXB;
  logic [1:0]  mouseYA, mouseYB;
  logic [17:0] pixA, pixB;
  logic [17:0] romA1, romB1;
  logic [4:0]  addrA, addrB;
  logic [1:0]  screenA, screenB;
  logic [2:0]  xA, xB;
  logic [1:0]  yA, yB;
  logic [5:0]  colA, colB;
  logic        weA, weB, doneA, doneB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_frame_scanner #(
    .H_RES(8), .V_RES(4), .COLOR_W(6), .NUM_SCREENS(3), .ROM_LAT(2),
    .CURSOR_MODE(0), .CURSOR_SIZE(2), .CURSOR_COLOR(CUR)
  ) dutA (
    .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .keyPress(keyPress),
    .iMouseX(mouseXA), .iMouseY(mouseYA), .iPixData(pixA),
    .oAddress(addrA), .oScreen(screenA), .x(xA), .y(yA), .color(colA),
    .writeEn(weA), .oFrameDone(doneA)
  );

  vga_frame_scanner #(
    .H_RES(8), .V_RES(4), .COLOR_W(6), .NUM_SCREENS(3), .ROM_LAT(2),
    .CURSOR_MODE(1), .CURSOR_SIZE(1), .CURSOR_COLOR(CUR)
  ) dutB (
    .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .keyPress(keyPress),
    .iMouseX(mouseXB), .iMouseY(mouseYB), .iPixData(pixB),
    .oAddress(addrB), .oScreen(screenB), .x(xB), .y(yB), .color(colB),
    .writeEn(weB), .oFrameDone(doneB)
  );

  // Lane 0 = address, lane 1 = 31 - address, lane 2 = address ^ 21.
  function automatic logic [17:0] romWord(input logic [4:0] a);
    logic [5:0] a6;
    a6 = {1'b0, a};
    return {a6 ^ 6'd21, 6'd31 - a6, a6};
  endfunction

  function automatic logic [5:0] laneVal(input int s, input int p);
    logic [17:0] w;
    w = romWord(5'(p));
    return w[s*6 +: 6];
  endfunction

  // Two-cycle ROM per DUT.
  always @(posedge clk) begin
    romA1 <= romWord(addrA);
    pixA  <= romA1;
    romB1 <= romWord(addrB);
    pixB  <= romB1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pressKey();
    keyPress = 1'b1;
    repeat (5) @(negedge clk);
    keyPress = 1'b0;
    @(negedge clk);
  endtask

  // Fires one V_SYNC fall and follows the frame for 40 cycles; cyc 0 is the address-0 cycle.
  task automatic doFrame(input int expScreen, input bit glitch, input bit keyAtEdge, input int resetAt);
    bit aborted;
    aborted = 1'b0;
    V_SYNC = 1'b1;
    @(negedge clk);
    @(negedge clk);
    V_SYNC = 1'b0;
    if (keyAtEdge) keyPress = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (aborted) begin
        check("abort_we", weA, 0);
        check("abort_done", doneA, 0);
        iReset = 1'b0;
      end else if (resetAt >= 0 && cyc == resetAt + 1) begin
        check("rst_we", weA, 0);
        check("rst_done", doneA, 0);
        check("rst_addr", addrA, 0);
        check("rst_screen", screenA, 0);
        aborted = 1'b1;
      end else begin
        int p, ex, ey;
        bit expWe, curA, curB;
        expWe = (cyc >= 2) && (cyc < 34);
        if (cyc < 32) begin
          check("addrA", addrA, cyc);
          check("addrB", addrB, cyc);
        end
        check("weA", weA, expWe);
        check("weB", weB, expWe);
        check("doneA", doneA, cyc == 33);
        check("doneB", doneB, cyc == 33);
        check("screen", screenA, expScreen);
        if (expWe) begin
          p  = cyc - 2;
          ex = p % 8;
          ey = p / 8;
          curA = (ex == 3) || (ey == 1);
          curB = (ex <= 1) && (ey <= 1);
          check("xA", xA, ex);
          check("yA", yA, ey);
          check("colA", colA, curA ? CUR : laneVal(expScreen, p));
          check("colB", colB, curB ? CUR : laneVal(expScreen, p));
        end
      end
      if (glitch && cyc == 10) V_SYNC = 1'b1;
      if (glitch && cyc == 12) V_SYNC = 1'b0;
      if (keyAtEdge && cyc == 3) keyPress = 1'b0;
      if (resetAt >= 0 && cyc == resetAt) iReset = 1'b1;
    end
  endtask

  initial begin
    iReset   = 1'b1;
    V_SYNC   = 1'b0;
    keyPress = 1'b0;
    mouseXA  = 3'd3;
    mouseYA  = 2'd1;
    mouseXB  = 3'd0;
    mouseYB  = 2'd0;

    @(negedge clk);
    check("reset_addr", addrA, 0);
    check("reset_screen", screenA, 0);
    check("reset_x", xA, 0);
    check("reset_y", yA, 0);
    check("reset_color", colA, 0);
    check("reset_we", weA, 0);
    check("reset_done", doneA, 0);
    @(negedge clk);
    iReset = 1'b0;
    @(negedge clk);

    // Extra V_SYNC fall mid-scan must not disturb or retrigger.
    doFrame(0, 1'b1, 1'b0, -1);

    pressKey();
    doFrame(1, 1'b0, 1'b0, -1);
    pressKey();
    doFrame(2, 1'b0, 1'b0, -1);
    pressKey();
    doFrame(0, 1'b0, 1'b0, -1);

    // Key held across two frames advances once.
    keyPress = 1'b1;
    doFrame(1, 1'b0, 1'b0, -1);
    doFrame(1, 1'b0, 1'b0, -1);
    keyPress = 1'b0;
    @(negedge clk);
    doFrame(1, 1'b0, 1'b0, -1);

    // Press on the edge cycle lands on the next frame.
    doFrame(1, 1'b0, 1'b1, -1);
    doFrame(2, 1'b0, 1'b0, -1);

    // Reset at address 10 aborts the frame; the next edge gives a full frame on screen 0.
    doFrame(2, 1'b0, 1'b0, 10);
    iReset = 1'b0;
    doFrame(0, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
